// File: rtl/fifo_param_n.sv
// Parametrised DEPTH-entry, WIDTH-bit FIFO on guarded-method (__ENA/__RDY) interfaces
// with occupancy count and synchronous flush; define FIFO_PARAM_N_PIPELINE_EN for enq-when-full-with-deq.
module fifo_param_n #(
  parameter int WIDTH = 704,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             in_enq__ENA,
  input  logic [WIDTH-1:0] in_enq_v,
  output logic             in_enq__RDY,
  input  logic             out_deq__ENA,
  output logic             out_deq__RDY,
  output logic [WIDTH-1:0] out_first,
  output logic             out_first__RDY,
  input  logic             in_clear__ENA,
  output logic [AW:0]      out_count
);

  localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rindex;
  logic [AW-1:0]    r_windex;
  logic [AW:0]      r_count;

  logic w_enq_rdy;
  logic w_deq_rdy;
  logic w_enq_fire;
  logic w_deq_fire;

`ifdef FIFO_PARAM_N_PIPELINE_EN
  // A same-cycle dequeue frees the slot the enqueue is about to overwrite.
  assign w_enq_rdy = (r_count != L_FULL) || out_deq__ENA;
`else
  assign w_enq_rdy = (r_count != L_FULL);
`endif
  assign w_deq_rdy  = (r_count != '0);
  assign w_enq_fire = in_enq__ENA && w_enq_rdy;
  assign w_deq_fire = out_deq__ENA && w_deq_rdy;

  assign in_enq__RDY    = w_enq_rdy;
  assign out_deq__RDY   = w_deq_rdy;
  assign out_first__RDY = w_deq_rdy;
  assign out_first      = r_mem[r_rindex];
  assign out_count      = r_count;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_rindex <= '0;
      r_windex <= '0;
      r_count  <= '0;
    end else if (in_clear__ENA) begin
      r_rindex <= '0;
      r_windex <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq_fire) r_windex <= r_windex + AW'(1);
      if (w_deq_fire) r_rindex <= r_rindex + AW'(1);
      case ({w_enq_fire, w_deq_fire})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is deliberately left unreset; clear discards the same-cycle enqueue.
  always_ff @(posedge CLK) begin
    if (w_enq_fire && !in_clear__ENA) r_mem[r_windex] <= in_enq_v;
  end

endmodule

// File: doc/fifo_param_n.md
# fifo_param_n

Parametrised N-entry, W-bit FIFO that generalises the fixed two-entry, 704-bit FIFO with configurable width and depth. Adds an occupancy count, a synchronous flush method and an optional pipeline mode (enqueue into a full FIFO when a dequeue fires in the same cycle). It sits between producer and consumer modules on guarded-method interfaces (`__ENA`/`__RDY`) wherever more than two elements of slack are needed.

## Interface
- `WIDTH`, 704: element width in bits, ≥1.
- `DEPTH`, 4: number of entries; power of two, ≥2.
- `AW`, `$clog2(DEPTH)`: pointer width (derived, not overridden).
- `CLK`  in  1  clock; all state updates on the rising edge.
- `nRST`  in  1  reset; asynchronous, active-low.
- `in$enq__ENA`  in  1  enqueue request.
- `in$enq_v`  in  WIDTH  enqueue data.
- `in$enq__RDY`  out  1  enqueue permitted.
- `out$deq__ENA`  in  1  dequeue request.
- `out$deq__RDY`  out  1  dequeue permitted.
- `out$first`  out  WIDTH  head element.
- `out$first__RDY`  out  1  head valid.
- `in$clear__ENA`  in  1  synchronous flush; always ready.
- `out$count`  out  AW+1  current occupancy, 0..DEPTH.

## Operation
- State: `rindex`, `windex` (AW bits each, wrap modulo DEPTH), `count` (AW+1 bits), and storage `mem[DEPTH]` of WIDTH bits each. Storage is not reset.
- Effective fire signals are gated: `enq_fire = in$enq__ENA && in$enq__RDY` and `deq_fire = out$deq__ENA && out$deq__RDY`. An ENA asserted while the matching RDY is low is ignored, with no state change.
- `out$deq__RDY = out$first__RDY = (count != 0)`.
- `in$enq__RDY = (count != DEPTH)`; see Configuration for the pipeline-mode extension.
- `out$first = mem[rindex]`. The value is don't-care while `count == 0` and is not checked.
- On enq_fire: `mem[windex] <= in$enq_v`, then `windex <= windex+1`, wrapping from DEPTH-1 to 0.
- On deq_fire: `rindex <= rindex+1`, with the same wrap.
- count update:
  - enq only: count+1.
  - deq only: count−1.
  - both, or neither: unchanged.
- Simultaneous enq and deq with `0 < count < DEPTH`: both take effect and count is unchanged.
- Simultaneous enq and deq with `count == 0`: deq is not ready, so only the enq fires (no bypass).
- in$clear__ENA sets `rindex`, `windex` and `count` to 0.
  - It has priority over enq and deq in the same cycle; that enq's data is discarded.
  - Clear while empty is a no-op.
- No error outputs. Overflow and underflow are impossible because of the RDY gating.

## Timing
- While `nRST=0` and after release: `rindex=windex=count=0`, `in$enq__RDY=1`, `out$deq__RDY=out$first__RDY=0`, `out$count=0`.
- Reset asserted mid-operation discards all contents immediately (asynchronous). The first edge after release behaves as from empty.
- Enqueue-to-visible latency is 1 cycle: data enqueued at edge k appears on `out$first` after edge k when the FIFO was empty, with `out$first__RDY=1` from then on.
- All RDY outputs and `out$count` are combinational from registered state only, except the pipeline-mode term described under Configuration.
- Sustained throughput is 1 element/cycle whenever `0 < count < DEPTH`.

## Configuration
- Macro `FIFO_PARAM_N_PIPELINE_EN`.
- Defined: `in$enq__RDY = (count != DEPTH) || out$deq__ENA`.
  - When full, a same-cycle dequeue frees a slot, so enq and deq both fire and count stays at DEPTH.
  - `mem[windex]` is written while `windex == rindex`; the old head leaves in that cycle.
  - This creates a combinational path from `out$deq__ENA` to `in$enq__RDY`.
- Undefined: `in$enq__RDY = (count != DEPTH)`. There are no input-to-RDY combinational paths. When full, enq waits one cycle after a deq.

## Test plan
- Reset, then fill: DEPTH=4, WIDTH=8. Enq 0x11, 0x22, 0x33, 0x44 on consecutive cycles.
  - Required: count goes 1,2,3,4; `in$enq__RDY=0` at count 4; `out$first=0x11`.
- Drain and wrap: after the fill, deq ×4, then enq 0x55 and deq it.
  - Required: data out in order 0x11..0x44 then 0x55; pointers wrap from 3 to 0; count ends at 0; `out$deq__RDY=0`.
- Simultaneous events:
  - count=2, enq 0xAA with deq: count stays 2 and the head advances.
  - count=0, enq with deq asserted: only the enq fires and count becomes 1.
- Full plus deq plus enq:
  - With `FIFO_PARAM_N_PIPELINE_EN`: count stays 4 and the new element appears 4th in order.
  - Without it: the enq is ignored and count goes to 3.
- Clear: at count=3, assert clear together with enq 0x77.
  - Required: count=0 on the next cycle, 0x77 is never dequeued, and a following enq 0x88 is at the head.
- Async reset mid-stream: with count=2, pulse `nRST` low between edges.
  - Required: count=0 and RDYs return to their reset values immediately, without waiting for a clock edge.
